// File: rtl/fm_sb_pkg.sv
// rtl/fm_sb_pkg.sv - shared types for the scan-buffer playback block
package fm_sb_pkg;

    localparam int pb_mode_width = 2;

    typedef enum logic [pb_mode_width-1:0] {
        PB_OFF    = 2'd0,
        PB_SINGLE = 2'd1,
        PB_LOOP   = 2'd2,
        PB_RSVD   = 2'd3
    } pb_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } pb_state_e;

    // Reserved encoding behaves exactly like off.
    function automatic logic mode_active(input logic [pb_mode_width-1:0] mode);
        return (mode == PB_SINGLE) || (mode == PB_LOOP);
    endfunction

endpackage

// File: rtl/fm_sb_playback_if.sv
// rtl/fm_sb_playback_if.sv - playback word stream with valid/ready handshake
interface fm_sb_playback_if #(
    parameter int DATA_W = 64
);
    logic              pb_valid;
    logic              pb_ready;
    logic [DATA_W-1:0] pb_data;

    modport master (output pb_valid, output pb_data, input  pb_ready);
    modport slave  (input  pb_valid, input  pb_data, output pb_ready);
endinterface

// File: rtl/fm_pb_ram.sv
// rtl/fm_pb_ram.sv - simple dual-port RAM, registered read with one-cycle latency
module fm_pb_ram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk_hs,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents and read register are deliberately not reset.
    always_ff @(posedge clk_hs) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/fm_sb_playback.sv
// rtl/fm_sb_playback.sv - memory playback engine; loop mode enabled by FM_SB_PLAYBACK_LOOP_EN
module fm_sb_playback
    import fm_sb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic                     clk_hs,
    input  logic                     rst_hs,
    input  logic                     freeze,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [pb_mode_width-1:0] playback_mode,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        last_addr,
    fm_sb_playback_if.master         pb,
    output logic                     pb_busy,
    output logic                     pb_done,
    output logic [15:0]              loop_count
);
`ifdef FM_SB_PLAYBACK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic [1:0]        rst_sync;
    logic              rst_n;
    pb_state_e         state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_q;
    logic              loop_q;
    logic [15:0]       loop_count_q;
    logic              pb_valid_q;
    logic              pb_busy_q;
    logic              pb_done_q;
    logic              hs;
    logic              ram_we;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Assertion is immediate, release is aligned to clk_hs.
    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign hs     = pb_valid_q && pb.pb_ready;
    assign ram_we = wr_en && freeze && (state == ST_IDLE);

    // Read ahead on a handshake so the next word is ready without a bubble.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = ptr;
        if (state == ST_FETCH) begin
            rd_en = 1'b1;
        end else if ((state == ST_RUN) && hs) begin
            rd_en   = 1'b1;
            rd_addr = (ptr == last_q) ? '0 : ptr + ADDR_W'(1);
        end
    end

    fm_pb_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_hs  (clk_hs),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_hs or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            loop_count_q <= '0;
            pb_valid_q   <= 1'b0;
            pb_busy_q    <= 1'b0;
            pb_done_q    <= 1'b0;
        end else begin
            pb_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && mode_active(playback_mode)) begin
                        state        <= ST_FETCH;
                        ptr          <= '0;
                        last_q       <= last_addr;
                        loop_q       <= LOOP_EN && (playback_mode == PB_LOOP);
                        loop_count_q <= '0;
                        pb_busy_q    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state      <= ST_RUN;
                    pb_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (hs) begin
                        // A mode switched off mid-run ends after the current word.
                        if (!mode_active(playback_mode)) begin
                            state      <= ST_IDLE;
                            pb_valid_q <= 1'b0;
                            pb_busy_q  <= 1'b0;
                        end else if (ptr == last_q) begin
                            if (loop_q) begin
                                ptr <= '0;
                                if (loop_count_q != 16'hFFFF) begin
                                    loop_count_q <= loop_count_q + 16'd1;
                                end
                            end else begin
                                state      <= ST_DONE;
                                pb_valid_q <= 1'b0;
                                pb_done_q  <= 1'b1;
                            end
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    pb_busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pb.pb_valid = pb_valid_q;
    assign pb.pb_data  = pb_valid_q ? rd_data : '0;
    assign pb_busy     = pb_busy_q;
    assign pb_done     = pb_done_q;
    assign loop_count  = loop_count_q;
endmodule

// File: tb/tb_fm_sb_playback.sv
// tb/tb_fm_sb_playback.sv - directed self-checking bench for fm_sb_playback
module tb_fm_sb_playback;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;

    logic              clk_hs = 1'b0;
    logic              rst_hs;
    logic              freeze;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        playback_mode;
    logic              start;
    logic [ADDR_W-1:0] last_addr;
    logic              pb_busy;
    logic              pb_done;
    logic [15:0]       loop_count;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp3 [6];
    logic        rdy3 [6];

    fm_sb_playback_if #(.DATA_W(DATA_W)) pb_if ();

    fm_sb_playback #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_hs        (clk_hs),
        .rst_hs        (rst_hs),
        .freeze        (freeze),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .playback_mode (playback_mode),
        .start         (start),
        .last_addr     (last_addr),
        .pb            (pb_if),
        .pb_busy       (pb_busy),
        .pb_done       (pb_done),
        .loop_count    (loop_count)
    );

    always #5 clk_hs = ~clk_hs;

    task automatic tick();
        @(posedge clk_hs);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        wr_en   = 1'b1;
        freeze  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        freeze  = 1'b0;
    endtask

    // Start pulse then FETCH; returns with the first word on the bus.
    task automatic launch(input logic [1:0] mode, input logic [ADDR_W-1:0] last);
        playback_mode = mode;
        last_addr     = last;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        chk("fetch_valid", pb_if.pb_valid, 1'b0);
        tick();
    endtask

    task automatic expect_done();
        chk("done_pulse", pb_done, 1'b1);
        chk("done_valid", pb_if.pb_valid, 1'b0);
        tick();
        chk("done_clear", pb_done, 1'b0);
        chk("idle_busy", pb_busy, 1'b0);
    endtask

    initial begin
        exp3 = '{64'hA0, 64'hA1, 64'hA1, 64'hA1, 64'hA2, 64'hA3};
        rdy3 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst_hs = 1'b0; freeze = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        playback_mode = 2'd0; start = 1'b0; last_addr = '0; pb_if.pb_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", pb_if.pb_valid, 1'b0);
        chk("rst_busy", pb_busy, 1'b0);
        chk("rst_done", pb_done, 1'b0);
        chk("rst_loop", loop_count, 16'd0);
        chk("rst_data", pb_if.pb_data, 64'd0);
        rst_hs = 1'b1;
        tick(); tick(); tick();

        for (int i = 0; i < 16; i++) mem_write(ADDR_W'(i), 64'hA0 + 64'(i));

        // Reserved and off modes do not start a run.
        playback_mode = 2'd3; start = 1'b1; tick();
        chk("mode3_ignored", pb_busy, 1'b0);
        playback_mode = 2'd0; tick();
        chk("mode0_ignored", pb_busy, 1'b0);
        start = 1'b0;

        // Single-shot of four words.
        launch(2'd1, 4'd3);
        for (int i = 0; i < 4; i++) begin
            chk("ss_valid", pb_if.pb_valid, 1'b1);
            chk("ss_data", pb_if.pb_data, 64'hA0 + 64'(i));
            chk("ss_busy", pb_busy, 1'b1);
            tick();
        end
        expect_done();

        // Mode 2 with a two-word window.
        launch(2'd2, 4'd1);
`ifdef FM_SB_PLAYBACK_LOOP_EN
        for (int i = 0; i < 10; i++) begin
            chk("loop_data", pb_if.pb_data, 64'hA0 + 64'(i % 2));
            chk("loop_count", loop_count, 16'(i / 2));
            if (i == 9) playback_mode = 2'd0;
            tick();
        end
        chk("loop_stop_valid", pb_if.pb_valid, 1'b0);
        chk("loop_stop_done", pb_done, 1'b0);
        chk("loop_stop_busy", pb_busy, 1'b0);
`else
        for (int i = 0; i < 2; i++) begin
            chk("m2_data", pb_if.pb_data, 64'hA0 + 64'(i));
            chk("m2_loop", loop_count, 16'd0);
            tick();
        end
        expect_done();
        chk("m2_loop_after", loop_count, 16'd0);
`endif
        playback_mode = 2'd0;

        // Backpressure; last_addr and start changes mid-run are ignored.
        launch(2'd1, 4'd3);
        for (int i = 0; i < 6; i++) begin
            pb_if.pb_ready = rdy3[i];
            if (i == 1) last_addr = 4'd0;
            start = (i == 2);
            chk("bp_valid", pb_if.pb_valid, 1'b1);
            chk("bp_data", pb_if.pb_data, exp3[i]);
            tick();
        end
        start = 1'b0;
        expect_done();

        // Writes with freeze low, or outside IDLE, are dropped.
        wr_en = 1'b1; freeze = 1'b0; wr_addr = 4'd0; wr_data = 64'hDEAD; tick();
        wr_en = 1'b0;
        playback_mode = 2'd1; last_addr = 4'd1; start = 1'b1; tick();
        start = 1'b0;
        wr_en = 1'b1; freeze = 1'b1; wr_addr = 4'd1; wr_data = 64'hBEEF; tick();
        chk("drop_w0", pb_if.pb_data, 64'hA0);
        tick();
        wr_en = 1'b0; freeze = 1'b0;
        chk("drop_w1", pb_if.pb_data, 64'hA1);
        tick();
        expect_done();

        // Write together with start; single-word window.
        wr_en = 1'b1; freeze = 1'b1; wr_addr = 4'd0; wr_data = 64'h55;
        launch(2'd1, 4'd0);
        wr_en = 1'b0; freeze = 1'b0;
        chk("wr_start_data", pb_if.pb_data, 64'h55);
        tick();
        expect_done();
        mem_write(4'd0, 64'hA0);

        // Full-depth window wraps the pointer arithmetic.
        launch(2'd1, 4'd15);
        for (int i = 0; i < 16; i++) begin
            chk("full_data", pb_if.pb_data, 64'hA0 + 64'(i));
            tick();
        end
        expect_done();

        // Mode off mid-run under backpressure.
        pb_if.pb_ready = 1'b0;
        launch(2'd1, 4'd3);
        playback_mode = 2'd0;
        tick();
        chk("abort_hold_valid", pb_if.pb_valid, 1'b1);
        chk("abort_hold_data", pb_if.pb_data, 64'hA0);
        pb_if.pb_ready = 1'b1;
        tick();
        chk("abort_valid", pb_if.pb_valid, 1'b0);
        chk("abort_done", pb_done, 1'b0);
        chk("abort_busy", pb_busy, 1'b0);

        // Reset mid-run, then replay original contents.
        launch(2'd1, 4'd3);
        tick();
        chk("pre_rst_data", pb_if.pb_data, 64'hA1);
        rst_hs = 1'b0;
        #1;
        chk("mrst_valid", pb_if.pb_valid, 1'b0);
        chk("mrst_busy", pb_busy, 1'b0);
        chk("mrst_data", pb_if.pb_data, 64'd0);
        chk("mrst_done", pb_done, 1'b0);
        tick();
        chk("mrst_done_after", pb_done, 1'b0);
        rst_hs = 1'b1;
        tick(); tick(); tick();
        launch(2'd1, 4'd1);
        chk("replay0", pb_if.pb_data, 64'hA0);
        tick();
        chk("replay1", pb_if.pb_data, 64'hA1);
        tick();
        expect_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
